// File: rtl/hamming_encoder_dm.sv
// SECDED (15,11)+overall-parity encoder that walks data memory: reads 11-bit messages
// as byte pairs and writes 16-bit codewords back as byte pairs through the shared port.
module hamming_encoder_dm #(
    parameter int W        = 8,
    parameter int N_WORDS  = 15,
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = 30
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         Start,
    input  logic [W-1:0] MemRdData,
    output logic [W-1:0] MemAddr,
    output logic         MemWrEn,
    output logic [W-1:0] MemWrData,
    output logic         Busy,
    output logic         Done
);

    localparam int            IW       = $clog2(N_WORDS + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_WORDS - 1);
    localparam logic [W-1:0]  SRC      = W'(SRC_BASE);
    localparam logic [W-1:0]  DST      = W'(DST_BASE);

    typedef enum logic [2:0] {
        IDLE,
        RD_LO,
        RD_HI,
        WR_LO,
        WR_HI,
        DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [IW-1:0] idx;
    logic [7:0]    data_lo;
    logic [2:0]    data_hi;
    logic [10:0]   msg;
    logic          p0, p1, p2, p4, p8;
    logic [7:0]    cw_lo;
    logic [7:0]    cw_hi;
    logic [W-1:0]  idx_w;
    logic [W-1:0]  word_off;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            idx     <= '0;
            data_lo <= '0;
            data_hi <= '0;
        end else begin
            case (state)
                IDLE:    if (Start) idx <= '0;
                RD_LO:   data_lo <= MemRdData[7:0];
                RD_HI:   data_hi <= MemRdData[2:0];
                WR_HI:   if (idx != LAST_IDX) idx <= idx + IW'(1);
                default: ;
            endcase
        end
    end

    // msg[k-1] is message bit b_k; codeword bit n is Hamming position n, so the
    // decoder's syndrome value directly names the flipped bit.
    assign msg   = {data_hi, data_lo};
    assign p8    = ^msg[10:4];
    assign p4    = ^{msg[10], msg[9], msg[8], msg[7], msg[3], msg[2], msg[1]};
    assign p2    = ^{msg[10], msg[9], msg[6], msg[5], msg[3], msg[2], msg[0]};
    assign p1    = ^{msg[10], msg[8], msg[6], msg[4], msg[3], msg[1], msg[0]};
    assign p0    = ^{msg, p1, p2, p4, p8};
    assign cw_hi = {msg[10:4], p8};
    assign cw_lo = {msg[3], msg[2], msg[1], p4, msg[0], p2, p1, p0};

    assign idx_w    = W'(idx);
    assign word_off = idx_w << 1;

    always_comb begin
        state_next = state;
        MemAddr    = '0;
        MemWrEn    = 1'b0;
        MemWrData  = '0;
        case (state)
            IDLE: begin
                if (Start) state_next = RD_LO;
            end
            RD_LO: begin
                MemAddr    = SRC + word_off;
                state_next = RD_HI;
            end
            RD_HI: begin
                MemAddr    = SRC + word_off + W'(1);
                state_next = WR_LO;
            end
            WR_LO: begin
                MemAddr    = DST + word_off;
                MemWrEn    = 1'b1;
                MemWrData  = W'(cw_lo);
                state_next = WR_HI;
            end
            WR_HI: begin
                MemAddr    = DST + word_off + W'(1);
                MemWrEn    = 1'b1;
                MemWrData  = W'(cw_hi);
                state_next = (idx == LAST_IDX) ? DONE : RD_LO;
            end
            DONE: begin
                if (!Start) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign Busy = (state == RD_LO) || (state == RD_HI) || (state == WR_LO) || (state == WR_HI);
    assign Done = (state == DONE);

endmodule

// File: tb/tb_hamming_encoder_dm.sv
// Bench for hamming_encoder_dm: byte memory model, write scoreboard, position-based
// reference encoder and syndrome decoder model.
module tb_hamming_encoder_dm;

    localparam int N   = 15;
    localparam int SRC = 0;
    localparam int DST = 30;

    logic       Clk;
    logic       Reset_n;
    logic       Start;
    logic [7:0] MemRdData;
    logic [7:0] MemAddr;
    logic       MemWrEn;
    logic [7:0] MemWrData;
    logic       Busy;
    logic       Done;

    logic [7:0] mem [0:255];
    logic       tb_we;
    logic [7:0] tb_addr;
    logic [7:0] tb_data;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t         sb[$];
    logic [15:0] exp_cw [0:N-1];
    int          n_checks = 0;
    int          n_errors = 0;
    logic        prev_en  = 1'b0;
    logic [7:0]  prev_addr = 8'h00;

    hamming_encoder_dm #(
        .W(8), .N_WORDS(N), .SRC_BASE(SRC), .DST_BASE(DST)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .MemRdData(MemRdData),
        .MemAddr(MemAddr), .MemWrEn(MemWrEn), .MemWrData(MemWrData),
        .Busy(Busy), .Done(Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    assign MemRdData = mem[MemAddr];

    always @(posedge Clk) begin
        if (MemWrEn) mem[MemAddr] <= MemWrData;
        else if (tb_we) mem[tb_addr] <= tb_data;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
        end
    endtask

    // Reference encoder: place data at non-power-of-two positions, then solve for parity.
    function automatic logic [15:0] encode_model(input logic [10:0] d);
        int          pos [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};
        logic [15:0] cw = '0;
        logic [3:0]  syn = '0;
        for (int k = 0; k < 11; k++) cw[pos[k]] = d[k];
        for (int p = 1; p < 16; p++) if (cw[p]) syn ^= p[3:0];
        cw[1] = syn[0];
        cw[2] = syn[1];
        cw[4] = syn[2];
        cw[8] = syn[3];
        cw[0] = ^cw[15:1];
        return cw;
    endfunction

    function automatic logic [4:0] decode_syndrome(input logic [15:0] cw);
        logic [3:0] syn = '0;
        for (int p = 1; p < 16; p++) if (cw[p]) syn ^= p[3:0];
        return {^cw, syn};
    endfunction

    // Write monitor: every DUT write must match the head of the scoreboard.
    always @(negedge Clk) begin
        if (Reset_n && MemWrEn) begin
            wr_t e;
            checkOutput("wr_repeat", {31'd0, prev_en && (prev_addr == MemAddr)}, 32'd0);
            checkOutput("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checkOutput("wr_addr", {24'd0, MemAddr}, {24'd0, e.addr});
                checkOutput("wr_data", {24'd0, MemWrData}, {24'd0, e.data});
            end
        end
        prev_en   = MemWrEn;
        prev_addr = MemAddr;
    end

    task automatic write_byte(input logic [7:0] a, input logic [7:0] d);
        @(negedge Clk);
        tb_we   = 1'b1;
        tb_addr = a;
        tb_data = d;
    endtask

    task automatic load_messages(input bit directed, input bit sentinel);
        logic [7:0] dlo [5] = '{8'h00, 8'hFF, 8'hFF, 8'h01, 8'h00};
        logic [7:0] dhi [5] = '{8'h00, 8'h07, 8'hFF, 8'h00, 8'h04};
        logic [7:0] lo, hi;
        for (int i = 0; i < N; i++) begin
            if (directed && i < 5) begin
                lo = dlo[i];
                hi = dhi[i];
            end else begin
                lo = 8'($urandom);
                hi = 8'($urandom);
            end
            write_byte(8'(SRC + 2 * i), lo);
            write_byte(8'(SRC + 2 * i + 1), hi);
            exp_cw[i] = encode_model({hi[2:0], lo});
        end
        if (sentinel) begin
            for (int i = 0; i < 2 * N; i++) write_byte(8'(DST + i), 8'hA5);
        end
        @(negedge Clk);
        tb_we = 1'b0;
    endtask

    task automatic push_expected();
        for (int i = 0; i < N; i++) begin
            sb.push_back(wr_t'{addr: 8'(DST + 2 * i), data: exp_cw[i][7:0]});
            sb.push_back(wr_t'{addr: 8'(DST + 2 * i + 1), data: exp_cw[i][15:8]});
        end
    endtask

    task automatic check_memory();
        logic [15:0] cw;
        for (int i = 0; i < N; i++) begin
            cw = {mem[DST + 2 * i + 1], mem[DST + 2 * i]};
            checkOutput("mem_cw", {16'd0, cw}, {16'd0, exp_cw[i]});
            checkOutput("syndrome", {27'd0, decode_syndrome(cw)}, 32'd0);
        end
        checkOutput("sb_drained", sb.size(), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        checkOutput({tag, "_busy"}, {31'd0, Busy}, 32'd0);
        checkOutput({tag, "_done"}, {31'd0, Done}, 32'd0);
        checkOutput({tag, "_wren"}, {31'd0, MemWrEn}, 32'd0);
        checkOutput({tag, "_addr"}, {24'd0, MemAddr}, 32'd0);
        checkOutput({tag, "_wdata"}, {24'd0, MemWrData}, 32'd0);
    endtask

    // Edge n==1 is the Start-sampling edge; Done must first appear after edge 4*N.
    task automatic applyStimulus(input bit hold, input int pulse_at, input int reset_at);
        bit seen = 1'b0;
        bit hit_reset = 1'b0;
        int lat = -1;
        @(negedge Clk);
        Start = 1'b1;
        for (int n = 1; n <= 4 * N + 20; n++) begin
            @(posedge Clk);
            #1;
            if (n == 1) begin
                checkOutput("busy_at_start", {31'd0, Busy}, 32'd1);
                if (!hold) Start = 1'b0;
            end
            if (n == pulse_at) Start = 1'b1;
            if (n == pulse_at + 1 && !hold) Start = 1'b0;
            if (n == 4 * N) checkOutput("busy_last_wr", {31'd0, Busy}, 32'd1);
            if (n == reset_at) begin
                checkOutput("wrhi_en", {31'd0, MemWrEn}, 32'd1);
                checkOutput("wrhi_addr", {24'd0, MemAddr}, 32'(DST + 11));
                Reset_n = 1'b0;
                #1;
                check_idle_outputs("rst_now");
                @(posedge Clk);
                #1;
                check_idle_outputs("rst_held");
                @(negedge Clk);
                Reset_n = 1'b1;
                sb.delete();
                hit_reset = 1'b1;
                break;
            end
            if (Done) begin
                seen = 1'b1;
                lat  = n - 1;
                break;
            end
        end
        if (!hit_reset) begin
            checkOutput("done_seen", {31'd0, seen}, 32'd1);
            checkOutput("done_latency", lat, 4 * N);
            checkOutput("busy_at_done", {31'd0, Busy}, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        Reset_n = 1'b0;
        Start   = 1'b0;
        tb_we   = 1'b0;
        tb_addr = 8'h00;
        tb_data = 8'h00;
        repeat (3) @(posedge Clk);
        #1;
        check_idle_outputs("reset");
        @(negedge Clk);
        Reset_n = 1'b1;

        $display("[TB] run 1: directed messages plus random");
        load_messages(1'b1, 1'b0);
        push_expected();
        applyStimulus(1'b0, -10, -10);
        check_memory();
        checkOutput("w0_lo", {24'd0, mem[DST + 0]}, 32'h00);
        checkOutput("w0_hi", {24'd0, mem[DST + 1]}, 32'h00);
        checkOutput("w1_lo", {24'd0, mem[DST + 2]}, 32'hFF);
        checkOutput("w1_hi", {24'd0, mem[DST + 3]}, 32'hFF);
        checkOutput("w2_lo", {24'd0, mem[DST + 4]}, 32'hFF);
        checkOutput("w2_hi", {24'd0, mem[DST + 5]}, 32'hFF);
        checkOutput("w3_lo", {24'd0, mem[DST + 6]}, 32'h0F);
        checkOutput("w3_hi", {24'd0, mem[DST + 7]}, 32'h00);
        checkOutput("w4_lo", {24'd0, mem[DST + 8]}, 32'h17);
        checkOutput("w4_hi", {24'd0, mem[DST + 9]}, 32'h81);

        $display("[TB] run 2: Start pulsed mid-run");
        load_messages(1'b0, 1'b0);
        push_expected();
        applyStimulus(1'b0, 20, -10);
        check_memory();
        @(posedge Clk);
        #1;
        check_idle_outputs("after_pulse");

        $display("[TB] run 3: Start held through DONE");
        load_messages(1'b0, 1'b0);
        push_expected();
        applyStimulus(1'b1, -10, -10);
        check_memory();
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk);
            #1;
            checkOutput("done_hold", {31'd0, Done}, 32'd1);
        end
        Start = 1'b0;
        @(posedge Clk);
        #1;
        check_idle_outputs("after_drop");

        $display("[TB] run 4: reset during WR_HI of word 5, then restart");
        load_messages(1'b0, 1'b1);
        push_expected();
        applyStimulus(1'b0, -10, 24);
        for (int i = 0; i < 5; i++) begin
            checkOutput("keep_lo", {24'd0, mem[DST + 2 * i]}, {24'd0, exp_cw[i][7:0]});
            checkOutput("keep_hi", {24'd0, mem[DST + 2 * i + 1]}, {24'd0, exp_cw[i][15:8]});
        end
        checkOutput("keep_w5_lo", {24'd0, mem[DST + 10]}, {24'd0, exp_cw[5][7:0]});
        checkOutput("untouched_w5_hi", {24'd0, mem[DST + 11]}, 32'hA5);
        checkOutput("untouched_w6_lo", {24'd0, mem[DST + 12]}, 32'hA5);
        push_expected();
        applyStimulus(1'b0, -10, -10);
        check_memory();

        repeat (2) @(posedge Clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/hamming_encoder_dm.md
# hamming_encoder_dm

Sequential (15,11)+overall-parity Hamming encoder that walks data memory, reads N_WORDS 11-bit messages stored as byte pairs, and writes back 16-bit SECDED codewords as byte pairs. It is the transmit-side counterpart of the syndrome decode path. Its codeword bit layout is exactly the one the decoder's syndrome-to-position mapping expects: syndrome 3 selects bit b1, and syndrome 15 selects bit b11. It shares the single data-memory port with the core, which holds off its own accesses while Busy is high.

## Interface
- W, 8, data-memory data and address width
- N_WORDS, 15, messages encoded per Start; legal range 1..2^(W-1)
- SRC_BASE, 0, byte address of the first message low byte
- DST_BASE, 30, byte address of the first codeword low byte; SRC_BASE+2*N_WORDS and DST_BASE+2*N_WORDS must each be ≤ 2^W
- Clk  input  1  clock; all state updates on the rising edge
- Reset_n  input  1  asynchronous, active-low reset
- Start  input  1  level request, sampled only in IDLE
- MemRdData  input  W  data memory read data; combinational read of MemAddr in the same cycle
- MemAddr  output  W  data memory byte address
- MemWrEn  output  1  write strobe; memory writes MemWrData at MemAddr on the rising edge
- MemWrData  output  W  write data
- Busy  output  1  high in every state except IDLE and DONE
- Done  output  1  high while in DONE

## Operation
- Message i: low byte at SRC_BASE+2i = d[8:1]; high byte at SRC_BASE+2i+1, bits [2:0] = d[11:9], bits [7:3] ignored.
- Parity over message bits b1..b11:
  - p8 = ^{b11..b5}
  - p4 = ^{b11,b10,b9,b8,b4,b3,b2}
  - p2 = ^{b11,b10,b7,b6,b4,b3,b1}
  - p1 = ^{b11,b9,b7,b5,b4,b2,b1}
  - p0 = XOR of b1..b11, p1, p2, p4, p8
- Codeword output:
  - high byte = {b11,b10,b9,b8,b7,b6,b5,p8} → DST_BASE+2i+1
  - low byte = {b4,b3,b2,p4,b1,p2,p1,p0} → DST_BASE+2i
- FSM states: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE.
  - IDLE: Start=1 → RD_LO, clear word index Idx. Otherwise stay.
  - RD_LO: MemAddr=SRC_BASE+2·Idx; latch MemRdData into DataLo; → RD_HI.
  - RD_HI: MemAddr=SRC_BASE+2·Idx+1; latch MemRdData[2:0] into DataHi; → WR_LO.
  - WR_LO: MemAddr=DST_BASE+2·Idx, MemWrEn=1, MemWrData=codeword low byte; → WR_HI.
  - WR_HI: MemAddr=DST_BASE+2·Idx+1, MemWrEn=1, MemWrData=codeword high byte.
    - If Idx==N_WORDS-1 → DONE.
    - Else Idx+1 → RD_LO.
  - DONE: stay while Start=1; Start=0 → IDLE.
- Parity is computed combinationally from DataLo/DataHi; no extra pipeline stage.
- Address math is W-bit, modulo 2^W. Idx is a ceil(log2(N_WORDS+1))-bit counter.
- In IDLE and DONE: MemAddr=0, MemWrEn=0, MemWrData=0.
- Start is ignored in every non-IDLE state; it is neither queued nor restarts the run.
- Reset_n low at any time:
  - Immediately, asynchronously: state=IDLE, Idx=0, DataLo=0, DataHi=0.
  - Outputs: Busy=0, Done=0, MemWrEn=0, MemAddr=0, MemWrData=0.
  - Bytes already written stay in memory; no rollback.

## Timing
- Reset values: every output 0.
- Start sampled high at edge k: RD_LO occupies cycle k..k+1.
- The first write, the low byte of word 0, commits at edge k+3.
- Each word takes exactly 4 cycles; no stalls.
- Last write commits at edge k+4·N_WORDS. Done and Busy=0 are visible from that same edge onward.
- MemWrEn is never high in two consecutive cycles to the same address. Reads and writes never share a cycle.
- Start held high continuously produces a single run. A second run requires Start low for at least one cycle in DONE, then high again in IDLE.

## Test plan
- Message 0x000 (bytes 0x00,0x00) → codeword low 0x00, high 0x00 written to DST_BASE, DST_BASE+1.
- Message 0x7FF → low 0xFF, high 0xFF. Repeat with high byte 0xFF (garbage in [7:3]) → identical output.
- Message 0x001 → low 0x0F, high 0x00. Message 0x400 → low 0x17, high 0x81.
- Full N_WORDS=15 run with random messages vs. reference model:
  - All 30 destination bytes match.
  - Done rises exactly 60 cycles after the Start-sampling edge.
  - No writes occur outside DST_BASE..DST_BASE+29.
  - A decoder-model syndrome check over every output codeword gives 0.
- Start pulsed again mid-run: no restart, and Done timing is unchanged. Start held high through DONE → stays in DONE. Drop Start → IDLE the next cycle.
- Reset_n asserted during WR_HI of word 5:
  - All outputs go 0 immediately.
  - Bytes of words 0-4 and low byte of word 5 are preserved.
  - A new Start re-encodes from word 0.
